// File: rtl/maxpool1_layer_pkg.sv
// Shared constants and helpers for the first max-pool stage of the MNIST net.
// The optional output clamp is selected with the MAXPOOL1_RELU_EN macro (see top).
package maxpool1_layer_pkg;

    // Per-channel pixel width; pixels are two's-complement signed.
    localparam int DW = 8;

    // Frame geometry on either side of this stage.
    localparam int CONV1_OUT_W = 24;
    localparam int CONV1_OUT_H = 24;
    localparam int POOL1_OUT_W = 12;
    localparam int POOL1_OUT_H = 12;

    // Number of feature channels produced by conv1.
    localparam int CONV1_CH = 3;

    // Signed maximum; a tie returns the shared value.
    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool1_layer_if.sv
// Pixel stream bus around the max-pool stage.
// Handshake: valid-only, no ready. A beat transfers on every rising clock edge
// where the valid bit is high; the receiver must always accept it.
// master drives the input pixels and observes the pooled output; slave is the
// pooling block itself.
interface maxpool1_layer_if #(
    parameter int DW = maxpool1_layer_pkg::DW
);
    logic          in_valid;
    logic [DW-1:0] in_1;
    logic [DW-1:0] in_2;
    logic [DW-1:0] in_3;
    logic          out_valid;
    logic [DW-1:0] out_1;
    logic [DW-1:0] out_2;
    logic [DW-1:0] out_3;
    logic          out_last;

    modport master (
        output in_valid, in_1, in_2, in_3,
        input  out_valid, out_1, out_2, out_3, out_last
    );

    modport slave (
        input  in_valid, in_1, in_2, in_3,
        output out_valid, out_1, out_2, out_3, out_last
    );
endinterface

// File: rtl/maxpool1_layer_channel.sv
// One channel of the 2x2 max pool: column-pair hold register, half-width
// line buffer for row pairing, compare datapath and the output register.
// With MAXPOOL1_RELU_EN defined, negative pooled results are clamped to zero
// in front of the output register.
module maxpool1_channel #(
    parameter int IN_W = maxpool1_layer_pkg::CONV1_OUT_W,
    parameter int LW   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic                                   col_odd,
    input  logic                                   row_odd,
    input  logic [LW-1:0]                          lb_idx,
    input  logic signed [maxpool1_layer_pkg::DW-1:0] in_data,
    output logic signed [maxpool1_layer_pkg::DW-1:0] out_data
);
    import maxpool1_layer_pkg::*;

    logic signed [DW-1:0] hold;
    logic signed [DW-1:0] lbuf [IN_W/2];
    logic signed [DW-1:0] hmax;
    logic signed [DW-1:0] pooled;
    logic signed [DW-1:0] result;

    assign hmax   = smax(hold, in_data);
    assign pooled = smax(lbuf[lb_idx], hmax);

`ifdef MAXPOOL1_RELU_EN
    assign result = pooled[DW-1] ? '0 : pooled;
`else
    assign result = pooled;
`endif

    // Storage is always written before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            if (!col_odd) begin
                hold <= in_data;
            end else if (!row_odd) begin
                lbuf[lb_idx] <= hmax;
            end
        end
    end

    // Output register loads only on a window-completing beat and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (in_valid && col_odd && row_odd) begin
            out_data <= result;
        end
    end

endmodule

// File: rtl/maxpool1_layer.sv
// 2x2 stride-2 max pool after conv1: three channels share one raster position
// counter and per-window control strobes; each channel owns its datapath.
// Optional feature macro: MAXPOOL1_RELU_EN (clamp negative outputs to zero).
module maxpool1_layer #(
    parameter int IN_W = maxpool1_layer_pkg::CONV1_OUT_W,
    parameter int IN_H = maxpool1_layer_pkg::CONV1_OUT_H,
    parameter int DW   = maxpool1_layer_pkg::DW
) (
    input  logic             clk,
    input  logic             rst,
    maxpool1_layer_if.slave  bus
);
    localparam int CW = (IN_W > 2) ? $clog2(IN_W) : 1;
    localparam int RW = (IN_H > 2) ? $clog2(IN_H) : 1;
    localparam int LW = (IN_W > 2) ? $clog2(IN_W / 2) : 1;

    // Frame geometry must tile exactly into 2x2 windows; the compare helper is
    // fixed at the package width.
    if ((IN_W % 2) != 0 || IN_W < 2 || (IN_H % 2) != 0 || IN_H < 2) begin : g_bad_geom
        $fatal(1, "maxpool1_layer: IN_W and IN_H must be even and >= 2");
    end
    if (DW != maxpool1_layer_pkg::DW) begin : g_bad_dw
        $fatal(1, "maxpool1_layer: DW must equal the package DW");
    end

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_end;
    logic          row_end;
    logic          emit;
    logic [LW-1:0] lb_idx;

    assign col_end = (col == CW'(IN_W - 1));
    assign row_end = (row == RW'(IN_H - 1));
    assign emit    = bus.in_valid & col[0] & row[0];
    assign lb_idx  = LW'(col >> 1);

    // Raster position of the next input beat; frozen while in_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.in_valid) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // One-cycle output strobe, flagged as last on the frame's final window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            bus.out_valid <= emit;
            bus.out_last  <= emit & col_end & row_end;
        end
    end

    maxpool1_channel #(.IN_W(IN_W), .LW(LW)) u_ch1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .col_odd  (col[0]),
        .row_odd  (row[0]),
        .lb_idx   (lb_idx),
        .in_data  (bus.in_1),
        .out_data (bus.out_1)
    );

    maxpool1_channel #(.IN_W(IN_W), .LW(LW)) u_ch2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .col_odd  (col[0]),
        .row_odd  (row[0]),
        .lb_idx   (lb_idx),
        .in_data  (bus.in_2),
        .out_data (bus.out_2)
    );

    maxpool1_channel #(.IN_W(IN_W), .LW(LW)) u_ch3 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .col_odd  (col[0]),
        .row_odd  (row[0]),
        .lb_idx   (lb_idx),
        .in_data  (bus.in_3),
        .out_data (bus.out_3)
    );

endmodule
